// File: rtl/float_arith_pkg.sv
// Shared defaults for the multiplier arbiter slice.
// Parameter defaults plus the requester id / tag width helpers.
package float_arith;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_W_DEF     = 12;
  localparam int MULT_LAT_DEF   = 3;
  localparam int FIFO_DEPTH_DEF = 4;

  // Width of a requester index (at least one bit).
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tag carried beside the multiplier: {valid, id}.
  function automatic int tag_w(input int n);
    return id_w(n) + 1;
  endfunction

endpackage

// File: rtl/mult_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
// Ports: clk_i/rst_i, wr_en/wr_data, rd_en/rd_data (head), count.
module mult_rsp_fifo
  import float_arith::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_wr;
  logic          do_rd;

  assign do_rd = rd_en && (count != '0);
  assign do_wr = wr_en &&
    ((count != (AW+1)'(DEPTH)) || do_rd);

  assign rd_data = mem[rp];

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external pipelined multiplier.
// Ports: req_* per-requester operands/handshake, mul_* to the
// multiplier, rsp_* ordered responses {id, product}.
// Option: MULT_ARBITER_PRIO0_EN gives requester 0 absolute priority.
module mult_arbiter
  import float_arith::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MULT_LAT   = MULT_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  output logic [DATA_W-1:0]         mul_a_o,
  output logic [DATA_W-1:0]         mul_b_o,
  input  logic [DATA_W-1:0]         mul_p_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic [id_w(NUM_REQ)-1:0]  rsp_id_o
);

  localparam int IW = id_w(NUM_REQ);
  localparam int TW = tag_w(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = IW + DATA_W;

  logic [IW-1:0]     ptr;
  logic [IW-1:0]     gnt_id;
  logic              gnt_any;
  logic              prio_hit;
  logic              room;
  logic              acc;
  logic              pop;
  logic [CW-1:0]     credit;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [TW-1:0]     tag [MULT_LAT+1];
  logic [FW-1:0]     rd_data;
  logic [CW-1:0]     count;

  // Search starts one past the last grant and wraps.
  always_comb begin
    int s;
    logic [IW-1:0] idx;
    s        = 0;
    idx      = '0;
    gnt_any  = 1'b0;
    gnt_id   = '0;
    prio_hit = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = IW'(s);
      if (!gnt_any && req_valid_i[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
`ifdef MULT_ARBITER_PRIO0_EN
    if (req_valid_i[0]) begin
      gnt_any  = 1'b1;
      gnt_id   = '0;
      prio_hit = 1'b1;
    end
`endif
  end

  // Credit is registered: a slot freed by a pop is
  // only offered again in the following cycle.
  assign room = !rst_i &&
    (credit < CW'(FIFO_DEPTH));
  assign acc  = room && gnt_any;

  always_comb begin
    req_ready_o = '0;
    if (acc) req_ready_o[gnt_id] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IW'(i)) begin
        sel_a = req_a_i[i*DATA_W +: DATA_W];
        sel_b = req_b_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign pop = rsp_valid_o && rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr     <= IW'(NUM_REQ - 1);
      mul_a_o <= '0;
      mul_b_o <= '0;
      credit  <= '0;
      for (int i = 0; i <= MULT_LAT; i++)
        tag[i] <= '0;
    end else begin
      if (acc) begin
        mul_a_o <= sel_a;
        mul_b_o <= sel_b;
        if (!prio_hit) ptr <= gnt_id;
      end
      // Stage 0 lines up with the operand register.
      tag[0] <= {acc, gnt_id};
      for (int i = 1; i <= MULT_LAT; i++)
        tag[i] <= tag[i-1];
      unique case ({acc, pop})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  mult_rsp_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (tag[MULT_LAT][IW]),
    .wr_data ({tag[MULT_LAT][IW-1:0], mul_p_i}),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (count)
  );

  // Head is masked so idle outputs read as zero.
  assign rsp_valid_o = (count != '0);
  assign rsp_data_o  = rsp_valid_o ?
    rd_data[DATA_W-1:0] : '0;
  assign rsp_id_o    = rsp_valid_o ?
    rd_data[FW-1:DATA_W] : '0;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a 3-cycle multiplier model.
// Grants, credits and responses are checked against a queue model.
module tb_mult_arbiter;

  localparam int N     = 4;
  localparam int DW    = 12;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
`ifdef MULT_ARBITER_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  valid = '0;
  logic [N-1:0]  ready_o;
  logic [N*DW-1:0] a;
  logic [N*DW-1:0] b;
  logic [DW-1:0] av [N] = '{default: '0};
  logic [DW-1:0] bv [N] = '{default: '0};
  logic [DW-1:0] mul_a;
  logic [DW-1:0] mul_b;
  logic [DW-1:0] mul_p;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_id;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int lg = N - 1;
  int outst = 0;
  int n_acc = 0;
  int last_acc_cyc = 0;
  logic [13:0] sb [$];
  int gnt_log [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a[i*DW +: DW] = av[i];
      b[i*DW +: DW] = bv[i];
    end
  end

  mult_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (valid),
    .req_ready_o (ready_o),
    .req_a_i     (a),
    .req_b_i     (b),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_p_i     (mul_p),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id)
  );

  function automatic logic [DW-1:0] fmul(
    input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [15:0] p;
    p = x[11:4] * y[11:4];
    return {p[7:0], 4'h0};
  endfunction

  // External multiplier: three register stages.
  logic [DW-1:0] m1 = '0, m2 = '0, m3 = '0;
  always @(posedge clk) begin
    m1 <= fmul(mul_a, mul_b);
    m2 <= m1;
    m3 <= m2;
  end
  assign mul_p = m3;

  task automatic chk(input string nm,
    input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  function automatic int exp_gnt(
    input logic [N-1:0] v, input int last);
    if (PRIO && v[0]) return 0;
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Request-side model: expected grant and credit state.
  always @(negedge clk) begin
    int e;
    logic [1:0] ei;
    logic [N-1:0] ex;
    logic [N-1:0] got;
    if (rst) begin
      chk("ready_in_reset", 32'(ready_o), 0);
      lg    = N - 1;
      outst = 0;
      sb.delete();
    end else begin
      e  = exp_gnt(valid, lg);
      ei = 2'(e);
      ex = '0;
      if (outst < DEPTH && e >= 0)
        ex = {{(N-1){1'b0}}, 1'b1} << ei;
      got = (outst >= DEPTH) ? ready_o
                             : (ready_o & valid);
      chk("grant", 32'(got), 32'(ex));
      chk("onehot", 32'($onehot0(ready_o)), 1);
      if (ex != '0) begin
        sb.push_back({ei, fmul(av[ei], bv[ei])});
        gnt_log.push_back(e);
        n_acc++;
        last_acc_cyc = cyc;
        outst++;
        if (!(PRIO && e == 0)) lg = e;
      end
      if (rsp_valid && rsp_ready) outst--;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_valid_idle", 32'(rsp_valid), 0);
      end else begin
        chk("rsp", 32'({rsp_id, rsp_data}), 32'(sb[0]));
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      av[i] = DW'($urandom);
      bv[i] = DW'($urandom);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    valid     = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 60 && sb.size() > 0; k++) tick();
    chk("drain", 32'(sb.size()), 0);
    repeat (8) tick();
  endtask

  task automatic send(input int id,
    input logic [DW-1:0] x, input logic [DW-1:0] y);
    int s;
    s      = n_acc;
    av[id] = x;
    bv[id] = y;
    valid  = N'(1 << id);
    for (int k = 0; k < 50 && n_acc == s; k++) tick();
    valid = '0;
    chk("send_accept", 32'(n_acc - s), 1);
  endtask

  task automatic expect_rsp(input logic [DW-1:0] ed,
    input int eid);
    do @(negedge clk);
    while (!rsp_valid && (cyc - last_acc_cyc) < 20);
    chk("latency", 32'(cyc - last_acc_cyc), LAT + 2);
    chk("rsp_data", 32'(rsp_data), 32'(ed));
    chk("rsp_id", 32'(rsp_id), 32'(eid));
    tick();
  endtask

  initial begin
    int s;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_mul_b", 32'(mul_b), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    tick();

    send(2, 12'h120, 12'h030);
    expect_rsp(12'h360, 2);
    send(1, 12'h120, 12'h340);
    expect_rsp(12'hA80, 1);
    drain();

    do_reset();
    gnt_log.delete();
    s     = n_acc;
    valid = '1;
    for (int k = 0; k < 60 && n_acc - s < 8; k++) begin
      rand_ops();
      tick();
    end
    valid = '0;
    chk("rr_count", 32'(n_acc - s), 8);
    for (int i = 0; i < 8; i++)
      chk("rr_order", 32'(gnt_log[i]), PRIO ? 0 : i % N);
    drain();

    do_reset();
    rsp_ready = 1'b0;
    s     = n_acc;
    valid = '1;
    repeat (12) begin
      rand_ops();
      tick();
    end
    chk("bp_accepts", 32'(n_acc - s), DEPTH);
    @(negedge clk);
    chk("bp_ready", 32'(ready_o), 0);
    tick();
    rsp_ready = 1'b1;
    repeat (20) begin
      rand_ops();
      tick();
    end
    chk("bp_resume", 32'(n_acc - s > DEPTH), 1);
    drain();

    do_reset();
    s     = n_acc;
    valid = 4'b0010;
    for (int k = 0; k < 40 && n_acc - s < 3; k++) begin
      rand_ops();
      tick();
    end
    valid = '0;
    chk("pre_rst_accepts", 32'(n_acc - s), 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(rsp_valid), 0);
      tick();
    end
    gnt_log.delete();
    valid = '1;
    tick();
    valid = '0;
    chk("post_rst_first", 32'(gnt_log[0]), 0);
    drain();

`ifdef MULT_ARBITER_PRIO0_EN
    do_reset();
    gnt_log.delete();
    valid = 4'b0011;
    repeat (10) begin
      rand_ops();
      tick();
    end
    valid = '0;
    chk("prio_some", 32'(gnt_log.size() > 0), 1);
    foreach (gnt_log[i])
      chk("prio_only0", 32'(gnt_log[i]), 0);
    drain();
`endif

    do_reset();
    repeat (400) begin
      rand_ops();
      valid     = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
